// File: rtl/key_click_decoder.sv
// key_click_decoder: turns debounced key presses into single/double/triple(+)/long click events.
// Optional long-press detection (HOLD state, hold_cnt) is compiled in with KEY_LONG_PRESS_EN.
module key_click_decoder #(
    parameter logic [25:0] WIN_MAX  = 26'd14_999_999,
    parameter logic [25:0] LONG_MAX = 26'd49_999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_flag,
    input  logic       key_in,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    output logic       evt_overflow
);
`ifdef KEY_LONG_PRESS_EN
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
    logic [25:0] hold_cnt, hold_nxt;
`else
    typedef enum logic {IDLE, WAIT} state_t;
    logic unused_ok;
    assign unused_ok = key_in ^ (^LONG_MAX);
`endif
    state_t      state, state_nxt;
    logic [1:0]  click_cnt, click_nxt, click_inc;
    logic [25:0] win_cnt, win_nxt;
    logic        emit;
    logic [2:0]  emit_code;

    assign click_inc = (click_cnt == 2'd3) ? 2'd3 : click_cnt + 2'd1;

    always_comb begin
        state_nxt = state;
        click_nxt = click_cnt;
        win_nxt   = win_cnt;
        emit      = 1'b0;
        emit_code = {1'b0, click_cnt};
`ifdef KEY_LONG_PRESS_EN
        hold_nxt  = hold_cnt;
`endif
        case (state)
            IDLE: if (key_flag) begin
                state_nxt = WAIT;
                click_nxt = 2'd1;
                win_nxt   = '0;
`ifdef KEY_LONG_PRESS_EN
                hold_nxt  = '0;
`endif
            end
            WAIT: if (key_flag) begin
                click_nxt = click_inc;
                win_nxt   = '0;
`ifdef KEY_LONG_PRESS_EN
                hold_nxt  = '0;
            end else if (hold_cnt == LONG_MAX && click_cnt == 2'd1) begin
                emit      = 1'b1;
                emit_code = 3'b100;
                state_nxt = HOLD;
`endif
            end else if (win_cnt == WIN_MAX) begin
                emit      = 1'b1;
                state_nxt = IDLE;
`ifdef KEY_LONG_PRESS_EN
            // while pressed the window is parked so it measures the gap since release
            end else if (!key_in) begin
                win_nxt   = '0;
                hold_nxt  = hold_cnt + 26'd1;
            end else begin
                win_nxt   = win_cnt + 26'd1;
                hold_nxt  = '0;
            end
            HOLD: if (key_in) state_nxt = IDLE;
`else
            end else begin
                win_nxt   = win_cnt + 26'd1;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            state     <= IDLE;
            click_cnt <= 2'd0;
            win_cnt   <= '0;
`ifdef KEY_LONG_PRESS_EN
            hold_cnt  <= '0;
`endif
        end else begin
            state     <= state_nxt;
            click_cnt <= click_nxt;
            win_cnt   <= win_nxt;
`ifdef KEY_LONG_PRESS_EN
            hold_cnt  <= hold_nxt;
`endif
        end
    end

    // a new event may replace one being consumed on the same edge; otherwise it is dropped
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            evt_valid    <= 1'b0;
            evt_code     <= 3'b000;
            evt_overflow <= 1'b0;
        end else if (emit && (!evt_valid || evt_ready)) begin
            evt_valid    <= 1'b1;
            evt_code     <= emit_code;
        end else if (emit) begin
            evt_overflow <= 1'b1;
        end else if (evt_ready) begin
            evt_valid    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_key_click_decoder.sv
// tb_key_click_decoder: randomized click gestures checked against a gap-based reference model.
module tb_key_click_decoder;
    localparam int WIN  = 100;
    localparam int LONG = 200;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b1;
    logic       key_flag = 1'b0;
    logic       key_in = 1'b1;
    logic       evt_ready = 1'b1;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       evt_overflow;

    int passed = 0;
    int total = 0;
    int flags[$];
    bit flag_at[0:4095];
    logic [2:0] exp_at[0:4095];

    key_click_decoder #(.WIN_MAX(26'd100), .LONG_MAX(26'd200)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flag(key_flag), .key_in(key_in),
        .evt_ready(evt_ready), .evt_valid(evt_valid), .evt_code(evt_code), .evt_overflow(evt_overflow)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse();
        key_flag = 1'b1;
        tick(1);
        key_flag = 1'b0;
    endtask

    function automatic logic [2:0] code_of(input int cnt);
        return (cnt >= 3) ? 3'b011 : 3'(cnt);
    endfunction

    // clicks separated by at most WIN+1 cycles merge; a gesture reports WIN+1 cycles after its last click
    task automatic run_model(input string name);
        int cnt, last, len;
        for (int i = 0; i < 4096; i++) begin
            flag_at[i] = 1'b0;
            exp_at[i]  = 3'b000;
        end
        cnt = 0;
        last = 0;
        foreach (flags[k]) begin
            flag_at[flags[k]] = 1'b1;
            if (cnt > 0 && flags[k] - last > WIN + 1) begin
                exp_at[last + WIN + 1] = code_of(cnt);
                cnt = 0;
            end
            cnt++;
            last = flags[k];
        end
        if (cnt > 0) exp_at[last + WIN + 1] = code_of(cnt);
        len = last + WIN + 10;
        for (int n = 0; n < len; n++) begin
            key_flag = flag_at[n];
            tick(1);
            total++;
            if (evt_valid !== (exp_at[n] != 3'b000) || (evt_valid && evt_code !== exp_at[n]))
                $display("FAIL %s cycle %0d: valid=%0b code=%03b, expected valid=%0b code=%03b",
                         name, n, evt_valid, evt_code, exp_at[n] != 3'b000, exp_at[n]);
            else passed++;
        end
        key_flag = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b1;
        tick(3);
        total++;
        if ({evt_valid, evt_code, evt_overflow} !== 5'b0)
            $display("FAIL reset: valid=%0b code=%03b ovf=%0b, expected 0/000/0", evt_valid, evt_code, evt_overflow);
        else passed++;
        sys_rst_n = 1'b0;
        tick(1);
    endtask

    task automatic test_patterns();
        flags = '{0};             run_model("single");
        flags = '{0, 50, 140};    run_model("triple");
        flags = '{0, 150};        run_model("two_singles");
        flags = '{0, 101};        run_model("flag_at_expiry");
        flags = '{0, 102};        run_model("flag_after_expiry");
        flags = '{0, 20, 40, 60}; run_model("saturate");
    endtask

    task automatic test_random();
        int t;
        for (int r = 0; r < 6; r++) begin
            flags.delete();
            t = 0;
            repeat ($urandom_range(1, 6)) begin
                flags.push_back(t);
                t += ($urandom_range(0, 3) == 0) ? $urandom_range(99, 104) : $urandom_range(1, 180);
            end
            run_model("random");
        end
    endtask

    task automatic test_backpressure();
        evt_ready = 1'b0;
        pulse();
        tick(101);
        total++;
        if (!evt_valid || evt_code !== 3'b001) $display("FAIL bp_first: valid=%0b code=%03b, expected 1/001", evt_valid, evt_code);
        else passed++;
        pulse();
        tick(101);
        total++;
        if (!evt_valid || evt_code !== 3'b001 || !evt_overflow)
            $display("FAIL bp_drop: valid=%0b code=%03b ovf=%0b, expected 1/001/1", evt_valid, evt_code, evt_overflow);
        else passed++;
        evt_ready = 1'b1;
        tick(1);
        total++;
        if (evt_valid || evt_code !== 3'b001 || !evt_overflow)
            $display("FAIL bp_accept: valid=%0b code=%03b ovf=%0b, expected 0/001/1", evt_valid, evt_code, evt_overflow);
        else passed++;
    endtask

    task automatic test_back_to_back();
        evt_ready = 1'b0;
        pulse();
        tick(101);
        pulse();
        tick(20);
        pulse();
        tick(100);
        evt_ready = 1'b1;
        tick(1);
        total++;
        if (!evt_valid || evt_code !== 3'b010)
            $display("FAIL b2b_replace: valid=%0b code=%03b, expected 1/010", evt_valid, evt_code);
        else passed++;
        tick(1);
        total++;
        if (evt_valid) $display("FAIL b2b_clear: valid=%0b, expected 0", evt_valid);
        else passed++;
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b0;
        pulse();
        tick(101);
        pulse();
        tick(30);
        pulse();
        tick(30);
        sys_rst_n = 1'b1;
        #1;
        total++;
        if ({evt_valid, evt_code, evt_overflow} !== 5'b0)
            $display("FAIL reset_mid: valid=%0b code=%03b ovf=%0b, expected 0/000/0", evt_valid, evt_code, evt_overflow);
        else passed++;
        evt_ready = 1'b1;
        tick(2);
        sys_rst_n = 1'b0;
        for (int n = 0; n < 250; n++) begin
            tick(1);
            total++;
            if (evt_valid) $display("FAIL reset_mid_quiet cycle %0d: valid=%0b, expected 0", n, evt_valid);
            else passed++;
        end
    endtask

`ifdef KEY_LONG_PRESS_EN
    task automatic test_long_press();
        key_in = 1'b0;
        pulse();
        tick(LONG);
        total++;
        if (evt_valid) $display("FAIL long_early: valid=%0b, expected 0", evt_valid);
        else passed++;
        tick(1);
        total++;
        if (!evt_valid || evt_code !== 3'b100) $display("FAIL long_event: valid=%0b code=%03b, expected 1/100", evt_valid, evt_code);
        else passed++;
        for (int n = 0; n < 210; n++) begin
            key_flag = (n == 10);
            if (n == 60) key_in = 1'b1;
            tick(1);
            total++;
            if (evt_valid) $display("FAIL long_quiet cycle %0d: valid=%0b, expected 0", n, evt_valid);
            else passed++;
        end
        key_flag = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_patterns();
        test_random();
        test_backpressure();
        test_back_to_back();
`ifdef KEY_LONG_PRESS_EN
        test_long_press();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/key_click_decoder.md
# key_click_decoder

Classifies debounced key presses into single, double, triple-or-more and (optionally) long-press events. Sits directly downstream of the key debouncer: consumes its one-cycle `key_flag` pulse plus the raw active-low `key_in` level. Emits one event code per gesture on a valid/ready interface to the control/display logic.

## Interface
- `WIN_MAX`, default 26'd14_999_999, multi-click window in cycles (300 ms @ 50 MHz).
- `LONG_MAX`, default 26'd49_999_999, long-press hold threshold in cycles (1 s @ 50 MHz); used only with `KEY_LONG_PRESS_EN`.
- `sys_clk` input 1: system clock, 50 MHz. One clock domain.
- `sys_rst_n` input 1: asynchronous, active-high reset; the name is kept despite the polarity.
- `key_flag` input 1: one-cycle pulse per debounced press, from the debouncer.
- `key_in` input 1: raw key level, 0 means pressed; ignored without `KEY_LONG_PRESS_EN`.
- `evt_valid` output 1: an event is held on `evt_code`.
- `evt_ready` input 1: the consumer accepts the event.
- `evt_code` output 3: 3'b001 single, 3'b010 double, 3'b011 triple or more, 3'b100 long.
- `evt_overflow` output 1: sticky flag, set when an event is dropped.

## Operation
- Reset values: `evt_valid`=0, `evt_code`=3'b000, `evt_overflow`=0. Reset also sets the state to IDLE and clears `click_cnt`, `win_cnt` and `hold_cnt`.
- Counters:
  - `win_cnt` and `hold_cnt` are 26-bit.
  - `click_cnt` is 2-bit and saturates at 3.
- IDLE:
  - `key_flag`=1 → WAIT, with `click_cnt`=1, `win_cnt`=0, `hold_cnt`=0.
- WAIT:
  - `key_flag`=1 → `click_cnt` increments (saturating), `win_cnt`=0, `hold_cnt`=0.
  - Otherwise `win_cnt` increments each cycle.
  - `win_cnt`==`WIN_MAX` and `key_flag`=0 → emit code {1'b0,`click_cnt`} and go to IDLE.
  - `key_flag` takes priority over window expiry in the same cycle.
- HOLD (macro only):
  - `key_flag` is ignored.
  - `key_in`=1 → IDLE, emitting nothing.
- Emission into the output register:
  - If `evt_valid`=0, or `evt_valid`=1 and `evt_ready`=1 on the same edge: load the code and set `evt_valid`=1 at that edge.
  - Else drop the new event and set `evt_overflow`=1. The held event is unchanged.
- Output handshake:
  - `evt_valid` and `evt_code` stay stable until an edge where `evt_ready`=1.
  - At that edge `evt_valid` clears, unless a new event loads on the same edge.
  - `evt_code` keeps its last value after it is consumed.
  - `evt_ready` with `evt_valid`=0 has no effect.
- `evt_overflow` clears only on reset.
- Reset mid-gesture discards any partial count; no event is emitted.

## Timing
- The event appears one cycle after the decision edge. `evt_valid` rises on the edge where `win_cnt`==`WIN_MAX` is sampled.
- A single press is reported `WIN_MAX`+1 cycles after the `key_flag` cycle (no macro).
- Back-to-back events are accepted at one per cycle; the state machine never stalls on `evt_ready`.
- A `key_flag` arriving in IDLE on the same edge that the output is consumed is handled independently.

## Configuration
- `KEY_LONG_PRESS_EN` defined:
  - HOLD state and `hold_cnt` are compiled in.
  - In WAIT, while `key_in`=0: `win_cnt` is held at 0, so the window measures the gap since release, and `hold_cnt` increments.
  - `key_in`=1 clears `hold_cnt`.
  - `hold_cnt`==`LONG_MAX` with `click_cnt`==1 → emit 3'b100 and go to HOLD.
  - With `click_cnt`>1 a long hold is not reported. The clicks are reported after release plus the window.
- Not defined:
  - `key_in` is unused, HOLD and `hold_cnt` do not exist, and code 3'b100 is never produced.
  - `win_cnt` runs from the last `key_flag` regardless of key level.

## Test plan
Bench parameters: `WIN_MAX`=100, `LONG_MAX`=200, `evt_ready` tied high unless stated otherwise.
- One `key_flag` pulse → `evt_valid` high for one cycle, `evt_code`=3'b001, 101 cycles after the pulse.
- Pulses at t=0, 50 and 140 → a single event 3'b011. Pulses at t=0 and 150 → two events, 3'b001 then 3'b001.
- `key_flag` in the same cycle that `win_cnt`==100 → no emission at that edge; the count increments and the window restarts.
- `evt_ready`=0, two gestures complete → the first event is held stable, the second is dropped and `evt_overflow`=1. Then `evt_ready`=1 → the first code is accepted and `evt_overflow` stays 1.
- Macro defined: `key_flag`, then `key_in` low for 250 cycles → 3'b100 at cycle 201 after the flag. No further event is emitted until release; a `key_flag` during HOLD is ignored.
- Assert reset with `click_cnt`=2 mid-window → all outputs return to their reset values and no event is emitted after deassertion.
